// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl
//   Drives an external serial "1010" Mealy detector (overlapping matches).
//   Each parallel word is accepted over a valid/ready handshake. The detector
//   is cleared for one cycle. The word is then shifted out MSB-first, one bit
//   per clock, while the detector's z output is collected. The per-word result
//   is presented over a valid/ready handshake, and a saturating running total
//   of match counts is kept.
//
// Ports
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready     input word handshake
//   in_data[WIDTH]        word to scan; bit WIDTH-1 is sent first
//   det_x                 serial bit to the detector
//   det_clr               detector reset (held during reset and the CLEAR cycle)
//   det_z                 detector z (combinational from detector state and det_x)
//   out_valid/out_ready   result handshake
//   out_count[CNT_W]      number of matches in the word
//   out_found             out_count != 0
//   out_first_idx[IDX_W]  bit position of first match (0 = first bit sent), 0 if none
//   stat_clr              synchronous clear of stat_total
//   stat_total[TOT_W]     saturating sum of out_count over accepted results
module seq_scan_ctrl #(
    parameter int WIDTH = 16,
    parameter int TOT_W = 16,
    localparam int CNT_W = $clog2(WIDTH + 1),
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             det_x,
    output logic             det_clr,
    input  logic             det_z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic             out_found,
    output logic [IDX_W-1:0] out_first_idx,
    input  logic             stat_clr,
    output logic [TOT_W-1:0] stat_total
);

    localparam int SUM_W = ((TOT_W > CNT_W) ? TOT_W : CNT_W) + 1;

    typedef enum logic [1:0] {IDLE, CLEAR, SCAN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0] bitcnt_q, bitcnt_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             found_q, found_d;
    logic [IDX_W-1:0] first_idx_q, first_idx_d;
    logic             clr_q, clr_d;
    logic [TOT_W-1:0] stat_total_q, stat_total_d;
    logic [TOT_W-1:0] stat_base;

    // Add with clamp at the all-ones value of the total counter.
    function automatic logic [TOT_W-1:0] sat_add(input logic [TOT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(a) + SUM_W'(b);
        if (sum > SUM_W'({TOT_W{1'b1}}))
            sat_add = {TOT_W{1'b1}};
        else
            sat_add = sum[TOT_W-1:0];
    endfunction

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bitcnt_d    = bitcnt_q;
        count_d     = count_q;
        found_d     = found_q;
        first_idx_d = first_idx_q;
        clr_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shreg_d     = in_data;
                    bitcnt_d    = '0;
                    count_d     = '0;
                    found_d     = 1'b0;
                    first_idx_d = '0;
                    clr_d       = 1'b1;   // detector held in S0 through CLEAR
                    state_d     = CLEAR;
                end
            end
            CLEAR: state_d = SCAN;
            SCAN: begin
                if (det_z) begin
                    count_d = count_q + CNT_W'(1);
                    if (!found_q) begin
                        first_idx_d = bitcnt_q;
                        found_d     = 1'b1;
                    end
                end
                shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
                bitcnt_d = bitcnt_q + IDX_W'(1);
                if (bitcnt_q == IDX_W'(WIDTH - 1))
                    state_d = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A clear coinciding with a result handshake leaves just that word's count.
    always_comb begin
        stat_base = stat_clr ? '0 : stat_total_q;
        if (state_q == DONE && out_ready)
            stat_total_d = sat_add(stat_base, count_q);
        else
            stat_total_d = stat_base;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            bitcnt_q     <= '0;
            count_q      <= '0;
            found_q      <= 1'b0;
            first_idx_q  <= '0;
            clr_q        <= 1'b0;
            stat_total_q <= '0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bitcnt_q     <= bitcnt_d;
            count_q      <= count_d;
            found_q      <= found_d;
            first_idx_q  <= first_idx_d;
            clr_q        <= clr_d;
            stat_total_q <= stat_total_d;
        end
    end

    assign in_ready      = (state_q == IDLE);
    assign out_valid     = (state_q == DONE);
    assign det_x         = (state_q == SCAN) & shreg_q[WIDTH-1];
    assign det_clr       = reset | clr_q;
    assign out_count     = count_q;
    assign out_found     = found_q;
    assign out_first_idx = first_idx_q;
    assign stat_total    = stat_total_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Testbench for seq_scan_ctrl with WIDTH=8 and a narrow 3-bit total so that
// saturation is reachable. Includes a behavioural "1010" overlapping Mealy
// detector driven by det_x/det_clr.
module tb_seq_scan_ctrl;

    localparam int WIDTH = 8;
    localparam int TOT_W = 3;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int IDX_W = $clog2(WIDTH);

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             det_x;
    logic             det_clr;
    logic             det_z;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_count;
    logic             out_found;
    logic [IDX_W-1:0] out_first_idx;
    logic             stat_clr;
    logic [TOT_W-1:0] stat_total;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_scan_ctrl #(.WIDTH(WIDTH), .TOT_W(TOT_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .det_x(det_x), .det_clr(det_clr), .det_z(det_z),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_count(out_count), .out_found(out_found), .out_first_idx(out_first_idx),
        .stat_clr(stat_clr), .stat_total(stat_total)
    );

    // Detector model: 0=S0, 1=seen "1", 2=seen "10", 3=seen "101".
    logic [1:0] ps;
    always_ff @(posedge clk or posedge det_clr) begin
        if (det_clr) ps <= 2'd0;
        else begin
            case (ps)
                2'd0:    ps <= det_x ? 2'd1 : 2'd0;
                2'd1:    ps <= det_x ? 2'd1 : 2'd2;
                2'd2:    ps <= det_x ? 2'd3 : 2'd0;
                default: ps <= det_x ? 2'd1 : 2'd2;
            endcase
        end
    end
    assign det_z = (ps == 2'd3) && !det_x;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Send one word, wait for its result, optionally stall the consumer,
    // then complete the result handshake and check the running total.
    task automatic run_word(input logic [7:0] d, input int stall, input logic hold,
                            input logic sclr, input int e_cnt, input int e_idx,
                            input int e_tot, input string tag);
        int cyc;
        int nclr;
        in_valid = 1'b1;
        in_data  = d;
        cyc = 0;
        while (!in_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, ".accept_ready"}, int'(in_ready), 1);
        @(negedge clk);
        if (!hold) in_valid = 1'b0;
        nclr = int'(det_clr);
        cyc  = 0;
        while (!out_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
            nclr += int'(det_clr);
        end
        chk({tag, ".latency"}, cyc, 9);
        chk({tag, ".clr_cycles"}, nclr, 1);
        chk({tag, ".count"}, int'(out_count), e_cnt);
        chk({tag, ".found"}, int'(out_found), (e_cnt != 0) ? 1 : 0);
        chk({tag, ".first_idx"}, int'(out_first_idx), e_idx);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk({tag, ".stall_valid"}, int'(out_valid), 1);
            chk({tag, ".stall_in_ready"}, int'(in_ready), 0);
            chk({tag, ".stall_count"}, int'(out_count), e_cnt);
            chk({tag, ".stall_idx"}, int'(out_first_idx), e_idx);
        end
        out_ready = 1'b1;
        stat_clr  = sclr;
        in_valid  = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        stat_clr  = 1'b0;
        chk({tag, ".post_valid"}, int'(out_valid), 0);
        chk({tag, ".post_in_ready"}, int'(in_ready), 1);
        chk({tag, ".total"}, int'(stat_total), e_tot);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        stat_clr  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.det_clr", int'(det_clr), 1);
        chk("rst.out_valid", int'(out_valid), 0);
        chk("rst.in_ready", int'(in_ready), 1);
        chk("rst.det_x", int'(det_x), 0);
        chk("rst.count", int'(out_count), 0);
        chk("rst.total", int'(stat_total), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst.det_clr_released", int'(det_clr), 0);

        // Alternating pattern: matches end at bits 3, 5, 7.
        run_word(8'b1010_1010, 0, 1'b0, 1'b0, 3, 3, 3, "t1");
        // No "1010" anywhere.
        run_word(8'b1111_0000, 0, 1'b0, 1'b0, 0, 0, 3, "t2");
        // First word leaves detector in "101"; the clear blocks a cross-word match.
        run_word(8'b0000_0101, 0, 1'b0, 1'b0, 0, 0, 3, "t3a");
        run_word(8'b0000_0000, 0, 1'b0, 1'b0, 0, 0, 3, "t3b");
        // Consumer stall with in_valid held high.
        run_word(8'b1010_0000, 5, 1'b1, 1'b0, 1, 3, 4, "t4");

        // Reset during the 4th SCAN cycle.
        in_valid = 1'b1;
        in_data  = 8'b1010_1010;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t5.rst_out_valid", int'(out_valid), 0);
        chk("t5.rst_in_ready", int'(in_ready), 1);
        chk("t5.rst_det_clr", int'(det_clr), 1);
        chk("t5.rst_total", int'(stat_total), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("t5.idle_out_valid", int'(out_valid), 0);
        chk("t5.idle_count", int'(out_count), 0);
        run_word(8'b0101_0100, 0, 1'b0, 1'b0, 2, 4, 2, "t5");

        // Running total, clears and saturation (3-bit total, max 7).
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        chk("t6.clr0", int'(stat_total), 0);
        run_word(8'b1010_1010, 0, 1'b0, 1'b0, 3, 3, 3, "t6a");
        run_word(8'b1010_1010, 0, 1'b0, 1'b0, 3, 3, 6, "t6b");
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        chk("t6.clr1", int'(stat_total), 0);
        run_word(8'b1010_1010, 0, 1'b0, 1'b0, 3, 3, 3, "t6c");
        run_word(8'b1010_1010, 0, 1'b0, 1'b1, 3, 3, 3, "t6d");
        run_word(8'b1010_1010, 0, 1'b0, 1'b0, 3, 3, 6, "t6e");
        run_word(8'b1010_1010, 0, 1'b0, 1'b0, 3, 3, 7, "t6sat");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
